// File: rtl/prt_scaler_pkg.sv
// Shared constants, widths and the framing state type for the scaler kernel MAC.
package prt_scaler_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } krnl_state_t;

  // Product of the zero-extended unsigned pixel and the signed coefficient.
  function automatic int prod_width(input int bpc, input int coef_w);
    return bpc + coef_w + 1;
  endfunction

  // Headroom for summing up to 'taps' products without overflow.
  function automatic int acc_width(input int bpc, input int coef_w, input int taps);
    return prod_width(bpc, coef_w) + $clog2(taps);
  endfunction

  // The tap counter must hold values up to taps-1.
  function automatic int cnt_width(input int taps);
    return (taps > 2) ? $clog2(taps) : 1;
  endfunction

  // Half an LSB of the output, used for round half-up before the shift.
  function automatic longint rnd_const(input int frac);
    return 64'sd1 <<< (frac - 1);
  endfunction

endpackage

// File: rtl/prt_scaler_krnl_sat.sv
// Round half-up, drop fraction bits and clamp the accumulator to an unsigned pixel.
module prt_scaler_krnl_sat
  import prt_scaler_pkg::*;
#(
  parameter int P_BPC       = 8,
  parameter int P_COEF_FRAC = 10,
  parameter int P_ACC_W     = 25
) (
  input  logic signed [P_ACC_W-1:0] acc_in,
  output logic        [P_BPC-1:0]   dat_out
);

  // One extra bit so adding the rounding constant can never wrap.
  localparam int SUM_W = P_ACC_W + 1;
  localparam logic signed [SUM_W-1:0] RND_C = SUM_W'(rnd_const(P_COEF_FRAC));
  localparam logic signed [SUM_W-1:0] MAX_C = SUM_W'((64'sd1 <<< P_BPC) - 64'sd1);

  logic signed [SUM_W-1:0] sum_s;
  logic signed [SUM_W-1:0] sh_s;

  // Round, rescale and saturate to the output range.
  always_comb begin
    sum_s = SUM_W'(acc_in) + RND_C;
    sh_s  = sum_s >>> P_COEF_FRAC;
    if (sh_s[SUM_W-1]) begin
      dat_out = {P_BPC{1'b0}};
    end else if (sh_s > MAX_C) begin
      dat_out = {P_BPC{1'b1}};
    end else begin
      dat_out = sh_s[P_BPC-1:0];
    end
  end

endmodule

// File: rtl/prt_scaler_krnl_mac.sv
// Kernel multiply-accumulate: per-tap product, kernel accumulation, rounded/clamped output.
module prt_scaler_krnl_mac
  import prt_scaler_pkg::*;
#(
  parameter int P_BPC       = 8,
  parameter int P_COEF_W    = 12,
  parameter int P_COEF_FRAC = 10,
  parameter int P_TAPS_MAX  = 10
) (
  input  logic                       CLK_IN,
  input  logic                       RST_IN,
  input  logic                       VLD_IN,
  input  logic                       FIRST_IN,
  input  logic                       LAST_IN,
  input  logic [P_BPC-1:0]           DAT_IN,
  input  logic signed [P_COEF_W-1:0] COEF_IN,
  output logic [P_BPC-1:0]           DAT_OUT,
  output logic                       VLD_OUT,
  output logic                       ERR_OUT
);

  localparam int PROD_W = prod_width(P_BPC, P_COEF_W);
  localparam int ACC_W  = acc_width(P_BPC, P_COEF_W, P_TAPS_MAX);
  localparam int CNT_W  = cnt_width(P_TAPS_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(P_TAPS_MAX - 1);

  krnl_state_t state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic err_d, err_q;

  logic s1_vld_d, s1_vld_q;
  logic s1_first_d, s1_first_q;
  logic s1_last_d, s1_last_q;
  logic signed [PROD_W-1:0] prod_d, prod_q;

  logic signed [ACC_W-1:0] acc_d, acc_q;
  logic emit_d, emit_q;

  logic [P_BPC-1:0] sat_s;
  logic [P_BPC-1:0] dat_out_d, dat_out_q;
  logic vld_out_d, vld_out_q;

  // Framing FSM: decides which taps enter the pipe, which restart or close a kernel.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    s1_vld_d   = 1'b0;
    s1_first_d = 1'b0;
    s1_last_d  = 1'b0;
    if (VLD_IN) begin
      case (state_q)
        IDLE: begin
          if (FIRST_IN) begin
            s1_vld_d   = 1'b1;
            s1_first_d = 1'b1;
            s1_last_d  = LAST_IN;
            cnt_d      = CNT_ONE;
            state_d    = LAST_IN ? IDLE : ACC;
          end else begin
            err_d = 1'b1;
          end
        end
        ACC: begin
          if (FIRST_IN) begin
            // Open kernel is abandoned; this tap starts a fresh one.
            err_d      = 1'b1;
            s1_vld_d   = 1'b1;
            s1_first_d = 1'b1;
            s1_last_d  = LAST_IN;
            cnt_d      = CNT_ONE;
            state_d    = LAST_IN ? IDLE : ACC;
          end else if (LAST_IN) begin
            s1_vld_d  = 1'b1;
            s1_last_d = 1'b1;
            state_d   = IDLE;
          end else if (cnt_q >= CNT_LIM) begin
            // Too many taps without LAST: drop the kernel, nothing is emitted.
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            s1_vld_d = 1'b1;
            cnt_d    = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = {CNT_W{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Framing state, tap counter and sticky error.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // S1 product: pixel zero-extended so the multiply stays signed.
  always_comb begin
    prod_d = PROD_W'($signed({1'b0, DAT_IN})) * PROD_W'(COEF_IN);
  end

  // S1 register: product plus the tap's framing controls.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      s1_vld_q   <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      prod_q     <= {PROD_W{1'b0}};
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      prod_q     <= prod_d;
    end
  end

  // S2 accumulate: the first tap reloads, later taps add.
  always_comb begin
    emit_d = s1_vld_q & s1_last_q;
    if (s1_vld_q) begin
      if (s1_first_q) begin
        acc_d = ACC_W'(prod_q);
      end else begin
        acc_d = acc_q + ACC_W'(prod_q);
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // S2 register: accumulator and the kernel-complete flag.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      acc_q  <= {ACC_W{1'b0}};
      emit_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      emit_q <= emit_d;
    end
  end

  prt_scaler_krnl_sat #(
    .P_BPC       (P_BPC),
    .P_COEF_FRAC (P_COEF_FRAC),
    .P_ACC_W     (ACC_W)
  ) u_sat (
    .acc_in  (acc_q),
    .dat_out (sat_s)
  );

  // S3 next values: capture a finished kernel, otherwise hold the last result.
  always_comb begin
    vld_out_d = emit_q;
    if (emit_q) begin
      dat_out_d = sat_s;
    end else begin
      dat_out_d = dat_out_q;
    end
  end

  // S3 register: output pixel and its one-cycle valid.
  always_ff @(posedge CLK_IN) begin
    if (RST_IN) begin
      dat_out_q <= {P_BPC{1'b0}};
      vld_out_q <= 1'b0;
    end else begin
      dat_out_q <= dat_out_d;
      vld_out_q <= vld_out_d;
    end
  end

  assign DAT_OUT = dat_out_q;
  assign VLD_OUT = vld_out_q;
  assign ERR_OUT = err_q;

endmodule

// File: tb/tb_prt_scaler_krnl_mac.sv
// Self-checking bench for prt_scaler_krnl_mac: scoreboard of expected pixels and emit cycles.
module tb_prt_scaler_krnl_mac;

  logic              CLK_IN;
  logic              RST_IN;
  logic              VLD_IN;
  logic              FIRST_IN;
  logic              LAST_IN;
  logic [7:0]        DAT_IN;
  logic signed [11:0] COEF_IN;
  logic [7:0]        DAT_OUT;
  logic              VLD_OUT;
  logic              ERR_OUT;

  typedef struct {
    int dat;
    int cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests;
  int   n_fail;
  int   cyc;

  // Reference model of the kernel framing and arithmetic.
  bit m_open;
  int m_cnt;
  int m_sum;
  int m_err;

  prt_scaler_krnl_mac dut (
    .CLK_IN   (CLK_IN),
    .RST_IN   (RST_IN),
    .VLD_IN   (VLD_IN),
    .FIRST_IN (FIRST_IN),
    .LAST_IN  (LAST_IN),
    .DAT_IN   (DAT_IN),
    .COEF_IN  (COEF_IN),
    .DAT_OUT  (DAT_OUT),
    .VLD_OUT  (VLD_OUT),
    .ERR_OUT  (ERR_OUT)
  );

  initial begin
    CLK_IN = 1'b0;
    forever #5 CLK_IN = ~CLK_IN;
  end

  always @(posedge CLK_IN) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected pixel from a full-precision kernel sum.
  task automatic model_emit(input int s, input int tap_cyc);
    exp_t e;
    int   r;
    r = (s + 512) >>> 10;
    if (r < 0) r = 0;
    else if (r > 255) r = 255;
    e.dat = r;
    e.cyc = tap_cyc + 3;
    sb_q.push_back(e);
  endtask

  task automatic model_tap(input bit f, input bit l, input int p, input int tap_cyc);
    if (!m_open) begin
      if (f) begin
        if (l) model_emit(p, tap_cyc);
        else begin m_open = 1'b1; m_cnt = 1; m_sum = p; end
      end else begin
        m_err = 1;
      end
    end else begin
      if (f) begin
        m_err = 1;
        if (l) begin model_emit(p, tap_cyc); m_open = 1'b0; end
        else begin m_sum = p; m_cnt = 1; end
      end else if (l) begin
        model_emit(m_sum + p, tap_cyc);
        m_open = 1'b0;
      end else if (m_cnt + 1 > 9) begin
        m_err  = 1;
        m_open = 1'b0;
      end else begin
        m_sum = m_sum + p;
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic tap(input bit f, input bit l, input int d, input int c);
    @(negedge CLK_IN);
    VLD_IN   = 1'b1;
    FIRST_IN = f;
    LAST_IN  = l;
    DAT_IN   = d[7:0];
    COEF_IN  = c[11:0];
    model_tap(f, l, d * c, cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK_IN);
      VLD_IN   = 1'b0;
      FIRST_IN = 1'b0;
      LAST_IN  = 1'b0;
    end
  endtask

  // Bounded wait for every expected result to appear.
  task automatic drain();
    idle(1);
    for (int i = 0; i < 12; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge CLK_IN);
    end
    idle(2);
    check("drain", sb_q.size(), 0);
    check("err", int'(ERR_OUT), m_err);
  endtask

  task automatic reset_dut();
    @(negedge CLK_IN);
    RST_IN   = 1'b1;
    VLD_IN   = 1'b0;
    FIRST_IN = 1'b0;
    LAST_IN  = 1'b0;
    m_open   = 1'b0;
    m_cnt    = 0;
    m_sum    = 0;
    m_err    = 0;
    sb_q.delete();
    @(negedge CLK_IN);
    check("rst_dat", int'(DAT_OUT), 0);
    check("rst_vld", int'(VLD_OUT), 0);
    check("rst_err", int'(ERR_OUT), 0);
    RST_IN = 1'b0;
  endtask

  // Monitor: every VLD_OUT must match the oldest expected result, in value and cycle.
  always @(negedge CLK_IN) begin
    exp_t e;
    if (!RST_IN && VLD_OUT === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_vld", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("dat", int'(DAT_OUT), e.dat);
        check("latency", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    cyc      = 0;
    RST_IN   = 1'b1;
    VLD_IN   = 1'b0;
    FIRST_IN = 1'b0;
    LAST_IN  = 1'b0;
    DAT_IN   = 8'd0;
    COEF_IN  = 12'sd0;
    reset_dut();

    // Unity single tap.
    tap(1'b1, 1'b1, 200, 1024);
    drain();
    check("single_200", int'(DAT_OUT), 200);

    // Bilinear back-to-back, then with a 2-cycle gap.
    tap(1'b1, 1'b0, 100, 512);
    tap(1'b0, 1'b1, 200, 512);
    drain();
    check("bilin_b2b", int'(DAT_OUT), 150);
    tap(1'b1, 1'b0, 100, 512);
    idle(2);
    tap(1'b0, 1'b1, 200, 512);
    drain();
    check("bilin_gap", int'(DAT_OUT), 150);

    // Rounding boundary.
    tap(1'b1, 1'b1, 1, 511);
    drain();
    check("round_down", int'(DAT_OUT), 0);
    tap(1'b1, 1'b1, 1, 512);
    drain();
    check("round_up", int'(DAT_OUT), 1);

    // Clamps.
    tap(1'b1, 1'b1, 255, -512);
    drain();
    check("clamp_low", int'(DAT_OUT), 0);
    tap(1'b1, 1'b0, 255, 1024);
    tap(1'b0, 1'b1, 255, 512);
    drain();
    check("clamp_high", int'(DAT_OUT), 255);

    // LAST without FIRST.
    reset_dut();
    tap(1'b0, 1'b1, 10, 1024);
    drain();
    check("nofirst_err", int'(ERR_OUT), 1);

    // Eleven taps, never LAST.
    reset_dut();
    tap(1'b1, 1'b0, 50, 100);
    for (int i = 0; i < 10; i++) tap(1'b0, 1'b0, 50, 100);
    drain();
    check("overrun_err", int'(ERR_OUT), 1);
    check("overrun_dat", int'(DAT_OUT), 0);

    // FIRST inside an open kernel restarts it.
    reset_dut();
    tap(1'b1, 1'b0, 50, 1024);
    tap(1'b1, 1'b0, 100, 1024);
    tap(1'b0, 1'b1, 100, 1024);
    drain();
    check("restart_dat", int'(DAT_OUT), 200);
    check("restart_err", int'(ERR_OUT), 1);

    // Reset mid-kernel with non-zero output and error pending.
    reset_dut();
    tap(1'b1, 1'b1, 200, 1024);
    tap(1'b0, 1'b0, 5, 5);
    drain();
    check("pre_rst_dat", int'(DAT_OUT), 200);
    tap(1'b1, 1'b0, 40, 1024);
    tap(1'b0, 1'b0, 40, 1024);
    reset_dut();
    idle(5);
    check("post_rst_dat", int'(DAT_OUT), 0);

    // Maximum-length kernel after the reset.
    tap(1'b1, 1'b0, 128, 102);
    for (int i = 0; i < 8; i++) tap(1'b0, 1'b0, 128, 102);
    tap(1'b0, 1'b1, 128, 102);
    drain();
    check("ten_tap", int'(DAT_OUT), 128);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
